// File: rtl/alu_seq_mc.sv
// alu_seq_mc: parametrised multicycle ALU with NZCV flags and iterative shifts.
// Optional iterative shift-and-add multiplier enabled by defining ALU_MUL_EN;
// without it, opcode 1100 behaves as PASS and completes in one cycle.
module alu_seq_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flag_write,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ORR  = 4'b0011;
  localparam logic [3:0] OP_EOR  = 4'b0100;
  localparam logic [3:0] OP_CLR  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic             fw_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW:0]     count;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
`endif

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;
  logic             start_shift;
  logic [WIDTH-1:0] imm_result;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] run_result;
  logic             run_c;

  assign sum_ext     = {1'b0, in_a} + {1'b0, in_b};
  assign diff_ext    = {1'b0, in_a} - {1'b0, in_b};
  assign shamt       = in_b[SHW-1:0];
  assign start_shift = (alu_control[3:2] == 2'b10) && (shamt != '0);

  // Single-cycle result and C/V for ops that finish straight from IDLE
  always_comb begin
    imm_result = in_a;
    imm_c      = flags[1];
    imm_v      = flags[0];
    case (alu_control)
      OP_ADD: begin
        imm_result = sum_ext[WIDTH-1:0];
        imm_c      = sum_ext[WIDTH];
        imm_v      = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        imm_result = diff_ext[WIDTH-1:0];
        imm_c      = ~diff_ext[WIDTH];
        imm_v      = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                     (diff_ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  imm_result = in_a & in_b;
      OP_ORR:  imm_result = in_a | in_b;
      OP_EOR:  imm_result = in_a ^ in_b;
      OP_CLR:  imm_result = '0;
      OP_MOV:  imm_result = in_b;
      default: imm_result = in_a;
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-and-add partial sum for the current multiplier bit
  always_comb begin
    acc_next = acc_q + (mplr_q[0] ? work_q : '0);
  end
`endif

  // One iteration of the running operation and the carry it would produce
  always_comb begin
    run_result = work_q;
    run_c      = flags[1];
    case (op_q)
      OP_LSL: begin
        run_result = {work_q[WIDTH-2:0], 1'b0};
        run_c      = work_q[WIDTH-1];
      end
      OP_LSR: begin
        run_result = {1'b0, work_q[WIDTH-1:1]};
        run_c      = work_q[0];
      end
      OP_ASR: begin
        run_result = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        run_c      = work_q[0];
      end
      OP_ROR: begin
        run_result = {work_q[0], work_q[WIDTH-1:1]};
        run_c      = work_q[0];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        run_result = acc_next;
        run_c      = flags[1];
      end
`endif
      default: begin
        run_result = work_q;
        run_c      = flags[1];
      end
    endcase
  end

  // Control FSM with registered result, flags, busy and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      fw_q   <= 1'b0;
      work_q <= '0;
      count  <= '0;
      result <= '0;
      flags  <= 4'b0000;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_MUL_EN
      mplr_q <= '0;
      acc_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            op_q <= alu_control;
            fw_q <= flag_write;
            busy <= 1'b1;
            if (start_shift) begin
              state  <= RUN;
              count  <= {1'b0, shamt};
              work_q <= in_a;
            end
`ifdef ALU_MUL_EN
            else if (alu_control == OP_MUL) begin
              state  <= RUN;
              count  <= (SHW+1)'(WIDTH);
              work_q <= in_a;
              mplr_q <= in_b;
              acc_q  <= '0;
            end
`endif
            else begin
              state  <= DONE;
              done   <= 1'b1;
              result <= imm_result;
              if (flag_write) begin
                flags <= {imm_result[WIDTH-1], (imm_result == '0), imm_c, imm_v};
              end
            end
          end
        end
        RUN: begin
          count <= count - (SHW+1)'(1);
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            acc_q  <= acc_next;
            work_q <= {work_q[WIDTH-2:0], 1'b0};
            mplr_q <= {1'b0, mplr_q[WIDTH-1:1]};
          end else begin
            work_q <= run_result;
          end
`else
          work_q <= run_result;
`endif
          if (count == (SHW+1)'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= run_result;
            if (fw_q) begin
              flags <= {run_result[WIDTH-1], (run_result == '0), run_c, flags[0]};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_mc.sv
// tb_alu_seq_mc: self-checking bench for alu_seq_mc at WIDTH=8.
// Expectations follow ALU_MUL_EN so the bench suits either build.
module tb_alu_seq_mc;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] alu_control;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       flag_write;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_flags = 4'b0000;

  alu_seq_mc #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .alu_control(alu_control),
    .in_a(in_a),
    .in_b(in_b),
    .flag_write(flag_write),
    .result(result),
    .flags(flags),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result, flags and latency from the opcode rules
  function automatic void model_op(input logic [3:0] op, input int a, input int b,
                                   input logic fw, input logic [3:0] fl_in,
                                   output int res, output logic [3:0] fl, output int lat);
    int k;
    int c;
    int v;
    int s;
    int sa;
    k   = b % 8;
    c   = fl_in[1];
    v   = fl_in[0];
    lat = 1;
    res = a;
    case (op)
      4'd0: begin
        s   = a + b;
        res = s & 255;
        c   = (s > 255) ? 1 : 0;
        v   = (((a ^ res) & (b ^ res) & 128) != 0) ? 1 : 0;
      end
      4'd1: begin
        res = (a - b) & 255;
        c   = (a >= b) ? 1 : 0;
        v   = (((a ^ b) & (a ^ res) & 128) != 0) ? 1 : 0;
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = 0;
      4'd6: res = b;
      4'd7: res = a;
      4'd8: if (k > 0) begin
        res = (a << k) & 255;
        c   = (a >> (8 - k)) & 1;
        lat = k + 1;
      end
      4'd9: if (k > 0) begin
        res = a >> k;
        c   = (a >> (k - 1)) & 1;
        lat = k + 1;
      end
      4'd10: if (k > 0) begin
        sa  = (a >= 128) ? a - 256 : a;
        res = (sa >>> k) & 255;
        c   = (a >> (k - 1)) & 1;
        lat = k + 1;
      end
      4'd11: if (k > 0) begin
        res = ((a >> k) | (a << (8 - k))) & 255;
        c   = (res >> 7) & 1;
        lat = k + 1;
      end
`ifdef ALU_MUL_EN
      4'd12: begin
        res = (a * b) & 255;
        lat = 9;
      end
`endif
      default: res = a;
    endcase
    if (fw) fl = {(res >= 128), (res == 0), c[0], v[0]};
    else    fl = fl_in;
  endfunction

  // Issues one operation and measures latency, busy cycles and the idle cycle after
  task automatic issue_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic fw, input bit noisy,
                          output logic [7:0] r, output logic [3:0] f,
                          output int lat, output int busy_cnt, output logic after);
    bit got_done;
    @(negedge clk);
    alu_control = op;
    in_a        = a;
    in_b        = b;
    flag_write  = fw;
    start       = 1'b1;
    @(posedge clk);
    #1;
    lat      = 1;
    busy_cnt = 0;
    got_done = 0;
    forever begin
      if (noisy) begin
        alu_control = 4'($urandom);
        in_a        = 8'($urandom);
        in_b        = 8'($urandom);
        flag_write  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (lat >= 40) break;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    r = result;
    f = flags;
    if (!got_done) lat = -1;
    @(posedge clk);
    #1;
    after = busy | done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    alu_control = 4'd0;
    in_a = 8'hFF;
    in_b = 8'h01;
    flag_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({result, flags, busy, done} !== 14'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got result=%h flags=%b busy=%b done=%b, want all 0",
               result, flags, busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    exp_flags = 4'b0000;
  endtask

  task automatic test_add_overflow();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    issue_op(4'd0, 8'h7F, 8'h01, 1'b1, 0, r, f, lat, bc, after);
    checks += 5;
    if (r !== 8'h80) begin failures++; $display("[TB] FAIL add_result: got %h want 80", r); end
    if (f !== 4'b1001) begin failures++; $display("[TB] FAIL add_flags: got %b want 1001", f); end
    if (lat !== 1) begin failures++; $display("[TB] FAIL add_latency: got %0d want 1", lat); end
    if (bc !== 1) begin failures++; $display("[TB] FAIL add_busy_cycles: got %0d want 1", bc); end
    if (after !== 1'b0) begin failures++; $display("[TB] FAIL add_idle_after: got %b want 0", after); end
    exp_flags = 4'b1001;
  endtask

  task automatic test_sub_and();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    issue_op(4'd1, 8'h05, 8'h05, 1'b1, 0, r, f, lat, bc, after);
    checks += 2;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL sub_result: got %h want 00", r); end
    if (f !== 4'b0110) begin failures++; $display("[TB] FAIL sub_flags: got %b want 0110", f); end
    issue_op(4'd2, 8'hF0, 8'h0F, 1'b1, 0, r, f, lat, bc, after);
    checks += 3;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL and_result: got %h want 00", r); end
    if (f !== 4'b0110) begin failures++; $display("[TB] FAIL and_flags: got %b want 0110", f); end
    if (lat !== 1) begin failures++; $display("[TB] FAIL and_latency: got %0d want 1", lat); end
    exp_flags = 4'b0110;
  endtask

  task automatic test_shifts();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    issue_op(4'd9, 8'h85, 8'h03, 1'b1, 0, r, f, lat, bc, after);
    checks += 4;
    if (r !== 8'h10) begin failures++; $display("[TB] FAIL lsr_result: got %h want 10", r); end
    if (f !== 4'b0010) begin failures++; $display("[TB] FAIL lsr_flags: got %b want 0010", f); end
    if (lat !== 4) begin failures++; $display("[TB] FAIL lsr_latency: got %0d want 4", lat); end
    if (bc !== 4) begin failures++; $display("[TB] FAIL lsr_busy_cycles: got %0d want 4", bc); end
    issue_op(4'd8, 8'h5A, 8'h08, 1'b1, 0, r, f, lat, bc, after);
    checks += 3;
    if (r !== 8'h5A) begin failures++; $display("[TB] FAIL lsl0_result: got %h want 5a", r); end
    if (f !== 4'b0010) begin failures++; $display("[TB] FAIL lsl0_flags: got %b want 0010", f); end
    if (lat !== 1) begin failures++; $display("[TB] FAIL lsl0_latency: got %0d want 1", lat); end
    exp_flags = 4'b0010;
  endtask

  task automatic test_mul();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    logic [7:0] want_r; logic [3:0] want_f; int want_lat;
`ifdef ALU_MUL_EN
    want_r = 8'h8F; want_f = 4'b1010; want_lat = 9;
`else
    want_r = 8'h0D; want_f = 4'b0010; want_lat = 1;
`endif
    issue_op(4'd12, 8'h0D, 8'h0B, 1'b1, 1, r, f, lat, bc, after);
    checks += 4;
    if (r !== want_r) begin failures++; $display("[TB] FAIL mul_result: got %h want %h", r, want_r); end
    if (f !== want_f) begin failures++; $display("[TB] FAIL mul_flags: got %b want %b", f, want_f); end
    if (lat !== want_lat) begin failures++; $display("[TB] FAIL mul_latency: got %0d want %0d", lat, want_lat); end
    if (after !== 1'b0) begin failures++; $display("[TB] FAIL mul_idle_after: got %b want 0", after); end
    exp_flags = want_f;
  endtask

  task automatic test_flag_hold();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    issue_op(4'd0, 8'hFF, 8'h01, 1'b0, 0, r, f, lat, bc, after);
    checks += 2;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL hold_result: got %h want 00", r); end
    if (f !== exp_flags) begin failures++; $display("[TB] FAIL hold_flags: got %b want %b", f, exp_flags); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    int done_seen;
    @(negedge clk);
    alu_control = 4'd12;
    in_a = 8'h0D;
    in_b = 8'h0B;
    flag_write = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({result, flags, busy, done} !== 14'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got result=%h flags=%b busy=%b done=%b, want all 0",
               result, flags, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin failures++; $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", done_seen); end
    exp_flags = 4'b0000;
    issue_op(4'd0, 8'h01, 8'h02, 1'b1, 0, r, f, lat, bc, after);
    checks += 3;
    if (r !== 8'h03) begin failures++; $display("[TB] FAIL post_reset_add: got %h want 03", r); end
    if (f !== 4'b0000) begin failures++; $display("[TB] FAIL post_reset_flags: got %b want 0000", f); end
    if (lat !== 1) begin failures++; $display("[TB] FAIL post_reset_latency: got %0d want 1", lat); end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] r; logic [3:0] f; int lat; int bc; logic after;
    logic [3:0] op; logic [7:0] a; logic [7:0] b; logic fw;
    int m_res; logic [3:0] m_fl; int m_lat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      fw = 1'($urandom);
      model_op(op, int'(a), int'(b), fw, exp_flags, m_res, m_fl, m_lat);
      issue_op(op, a, b, fw, (i % 3) == 0, r, f, lat, bc, after);
      checks += 4;
      if (r !== m_res[7:0]) begin failures++;
        $display("[TB] FAIL rand_result[%0d] op=%h a=%h b=%h: got %h want %h", i, op, a, b, r, m_res[7:0]); end
      if (f !== m_fl) begin failures++;
        $display("[TB] FAIL rand_flags[%0d] op=%h a=%h b=%h fw=%b: got %b want %b", i, op, a, b, fw, f, m_fl); end
      if (lat !== m_lat) begin failures++;
        $display("[TB] FAIL rand_latency[%0d] op=%h b=%h: got %0d want %0d", i, op, b, lat, m_lat); end
      if (bc !== m_lat) begin failures++;
        $display("[TB] FAIL rand_busy[%0d] op=%h: got %0d want %0d", i, op, bc, m_lat); end
      exp_flags = m_fl;
    end
  endtask

  // Scenario sequence and summary
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    alu_control = 4'd0;
    in_a = 8'h00;
    in_b = 8'h00;
    flag_write = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_and();
    test_shifts();
    test_mul();
    test_flag_hold();
    test_reset_mid_op();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_mc.md
# alu_seq_mc

Parametrised multicycle ALU for the multicycle ARM core's execute stage. Supersedes the fixed 8-bit ALU: `WIDTH`-bit datapath, full NZCV flag register, iterative barrel-free shifts and an optional iterative multiplier. Control FSM issues `start`, waits on `done`, and reads `result`/`flags`.

## Interface
- `WIDTH`, default 8: datapath width; power of two, minimum 4.
- `SHW`, localparam = $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  operation request, sampled only in IDLE.
- `alu_control`  in  4  opcode, captured with `start`.
- `in_a`, `in_b`  in  WIDTH  operands, captured with `start`.
- `flag_write`  in  1  update flags at completion; captured with `start`.
- `result`  out  WIDTH  registered result, held until next `done`.
- `flags`  out  4  registered {N,Z,C,V}.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0011 ORR
  - 0100 EOR
  - 0101 CLR (0)
  - 0110 MOV (B)
  - 0111 PASS (A)
  - 1000 LSL
  - 1001 LSR
  - 1010 ASR
  - 1011 ROR
  - 1100 MUL
  - all others: PASS.
- Shift amount = `in_b[SHW-1:0]`; upper bits ignored.
- FSM states:
  - IDLE: `start`=1 captures operands, opcode and `flag_write`.
    - Shift with amount>0 → RUN, counter=amount.
    - MUL → RUN, counter=WIDTH.
    - Else → DONE, result computed.
  - RUN:
    - Shift ops: one bit per cycle.
    - MUL: shift-and-add, one multiplier bit per cycle.
    - Counter decrements each cycle; counter=1 → DONE.
  - DONE: `done`=1, `result` valid, flags updated if captured `flag_write`=1; → IDLE unconditionally.
- Flags on update:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = NOT borrow (ARM convention), V = signed overflow.
  - Shifts, amount>0: C = last bit shifted/rotated out; V unchanged.
  - Shifts with amount 0, logical ops, MOV, PASS, CLR, MUL: C and V unchanged.
- MUL: low WIDTH bits of unsigned product.
- Arithmetic is WIDTH+1 bits internally; result truncated to WIDTH.
- `start` in RUN or DONE is ignored; there is no queue.
- Operand or opcode changes after capture have no effect.

## Timing
- `start` sampled at edge t.
- Single-cycle ops and shifts by 0: `done`=1 in cycle t+1.
- Shift by k: `done` in cycle t+k+1.
- MUL: `done` in cycle t+WIDTH+1.
- `result` and `flags` change only on the edge entering DONE (visible with `done`).
- Earliest back-to-back `start` is the cycle after `done`.
- Reset (`rst_n`=0 at an edge), including mid-operation:
  - state=IDLE; `result`=0, `flags`=0000, `busy`=0, `done`=0, counter=0.
  - An in-flight operation is aborted with no flag update.
  - `start` is ignored during reset.

## Configuration
- `ALU_MUL_EN` defined: opcode 1100 performs the iterative multiply described above.
- `ALU_MUL_EN` undefined:
  - No multiplier logic is generated.
  - Opcode 1100 decodes as PASS and completes in 1 cycle (`done` at t+1).

## Test plan
All scenarios at WIDTH=8.
- ADD 0x7F+0x01, `flag_write`=1 → `result`=0x80, NZCV=1001, `done` at t+1, `busy` high only that cycle.
- SUB 0x05−0x05, `flag_write`=1, then AND 0xF0&0x0F with `flag_write`=1 → first NZCV=0110; AND gives `result`=0x00, NZCV=0110 (C,V kept).
- LSR 0x85 by in_b=0x03 → `result`=0x10, C=1, `done` at t+4.
- Shift amount 0: LSL 0x5A by 0x08 (masked to 0) → `result`=0x5A, C unchanged, `done` at t+1.
- MUL 0x0D×0x0B with `ALU_MUL_EN` → `result`=0x8F, N=1, `done` at t+9; extra `start` pulses during busy ignored. Without the macro → `result`=0x0D at t+1.
- ADD with `flag_write`=0 leaves flags unchanged. `rst_n` low at t+4 of a MUL → all outputs 0 next cycle, no `done`; a fresh ADD 0x01+0x02 afterwards returns 0x03 at t'+1.
